// File: rtl/conv1d_seq_ctrl.sv
// Sequencer for a 1-D valid-mode convolution: walks output index j and tap k,
// issuing sample reads, accumulator control and one result write per output.
module conv1d_seq_ctrl #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 10,
    parameter int K_W    = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [K_W-1:0]    ksize_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    output logic              rd_req_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic              rd_gnt_i,
    input  logic              rd_valid_i,
    output logic              acc_clr_o,
    output logic              mac_en_o,
    output logic [K_W-1:0]    tap_idx_o,
    output logic              wr_valid_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    input  logic              wr_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    input  logic              clr_done_i
);

    typedef enum logic [2:0] {
        IDLE, CHECK, CLR, RD_REQ, RD_WAIT, MAC, WR, FIN
    } state_t;

    // Comparison width wide enough for j+K without overflow.
    localparam int CW = ((LEN_W > K_W) ? LEN_W : K_W) + 1;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [K_W-1:0]    ksize_q, ksize_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  j_q, j_d;
    logic [K_W-1:0]    k_q, k_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [CW-1:0] n_ext, ks_ext, j_ext, k_ext;

    assign n_ext  = CW'(len_q);
    assign ks_ext = CW'(ksize_q);
    assign j_ext  = CW'(j_q);
    assign k_ext  = CW'(k_q);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        ksize_d = ksize_q;
        src_d   = src_q;
        dst_d   = dst_q;
        j_d     = j_q;
        k_d     = k_q;
        done_d  = done_q;
        err_d   = err_q;

        if (clr_done_i) begin
            done_d = 1'b0;
            err_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d   = len_i;
                    ksize_d = ksize_i;
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((ksize_q == '0) || (ks_ext > n_ext)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    j_d     = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                k_d     = '0;
                state_d = RD_REQ;
            end
            RD_REQ: begin
                if (rd_gnt_i) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (rd_valid_i) state_d = MAC;
            end
            MAC: begin
                if ((k_ext + CW'(1)) < ks_ext) begin
                    k_d     = k_q + K_W'(1);
                    state_d = RD_REQ;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                if (wr_ready_i) begin
                    // j < N-K, rearranged so nothing can underflow.
                    if ((j_ext + ks_ext) < n_ext) begin
                        j_d     = j_q + LEN_W'(1);
                        state_d = CLR;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            ksize_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            ksize_q <= ksize_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Addresses derive only from held registers, so they stay put while stalled.
    assign rd_addr_o  = src_q + ADDR_W'(j_q) + ADDR_W'(k_q);
    assign wr_addr_o  = dst_q + ADDR_W'(j_q);
    assign tap_idx_o  = k_q;
    assign rd_req_o   = (state_q == RD_REQ);
    assign acc_clr_o  = (state_q == CLR);
    assign mac_en_o   = (state_q == MAC);
    assign wr_valid_o = (state_q == WR);
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_conv1d_seq_ctrl.sv
// Bench for conv1d_seq_ctrl: an ordered transaction model (clear, read, mac, write)
// checked every cycle against the DUT, plus directed runs with literal expectations.
module tb_conv1d_seq_ctrl;
    localparam int ADDR_W = 12;
    localparam int LEN_W  = 10;
    localparam int K_W    = 4;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic              clk = 1'b0;
    logic              rst_i, start_i, clr_done_i;
    logic [LEN_W-1:0]  len_i;
    logic [K_W-1:0]    ksize_i;
    logic [ADDR_W-1:0] src_base_i, dst_base_i;
    logic              rd_req_o, rd_gnt_i, rd_valid_i;
    logic [ADDR_W-1:0] rd_addr_o, wr_addr_o;
    logic              acc_clr_o, mac_en_o, wr_valid_o, wr_ready_i;
    logic [K_W-1:0]    tap_idx_o;
    logic              busy_o, done_o, err_o;

    always #5 clk = ~clk;

    conv1d_seq_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .K_W(K_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
        .ksize_i(ksize_i), .src_base_i(src_base_i), .dst_base_i(dst_base_i),
        .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o), .rd_gnt_i(rd_gnt_i),
        .rd_valid_i(rd_valid_i), .acc_clr_o(acc_clr_o), .mac_en_o(mac_en_o),
        .tap_idx_o(tap_idx_o), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o),
        .wr_ready_i(wr_ready_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .clr_done_i(clr_done_i)
    );

    typedef struct { int kind; int val; } ev_t;   // kind: 0 clear, 1 read, 2 mac, 3 write
    ev_t exp_q[$];
    int  rd_log[$];
    int  wr_log[$];

    int errors = 0;
    int checks = 0;

    // Responder policy, set by the stimulus process.
    int gdelay = 0, wdelay = 0, lat = 1, gap_exp = 0;
    bit spur = 1'b0;
    bit mon_en = 1'b0;

    // Running totals kept by the monitor.
    int rd_tot = 0, wr_tot = 0, busy_tot = 0, rdreq_tot = 0;
    int s_rd, s_wr, s_busy, s_rdreq, s_rdlog, s_wrlog;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Behavioural model: the full ordered transaction list of one run.
    task automatic expect_run(input int n, input int k, input int src, input int dst);
        if (k == 0 || k > n) return;
        for (int j = 0; j <= n - k; j++) begin
            exp_q.push_back('{0, 0});
            for (int t = 0; t < k; t++) begin
                exp_q.push_back('{1, (src + j + t) & AMASK});
                exp_q.push_back('{2, t});
            end
            exp_q.push_back('{3, (dst + j) & AMASK});
        end
    endtask

    task automatic pop_check(input int kind, input int val);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_event: got kind=%0d val=0x%0h, expected no event", kind, val);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", kind, e.kind);
            check("event_val", val, e.val);
        end
    endtask

    // Responder and compare process: drives handshakes, then checks this cycle's events.
    initial begin
        int  gw, ww, vcnt, cyc, last_clr, prev_rd_addr, prev_wr_addr;
        bit  prev_rd_hold, prev_wr_hold;
        gw = 0; ww = 0; vcnt = 0; cyc = 0; last_clr = -1;
        prev_rd_hold = 0; prev_wr_hold = 0; prev_rd_addr = 0; prev_wr_addr = 0;
        rd_gnt_i = 1'b0; rd_valid_i = 1'b0; wr_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_i || !mon_en) begin
                rd_gnt_i = 1'b0; rd_valid_i = 1'b0; wr_ready_i = 1'b0;
                gw = 0; ww = 0; vcnt = 0; last_clr = -1;
                prev_rd_hold = 0; prev_wr_hold = 0;
            end else begin
                rd_valid_i = 1'b0;
                if (vcnt > 0) begin
                    vcnt--;
                    if (vcnt == 0) rd_valid_i = 1'b1;
                end
                if (gdelay == 0) rd_gnt_i = 1'b1;
                else if (rd_req_o) begin
                    if (gw < gdelay) begin
                        rd_gnt_i = 1'b0;
                        gw++;
                        if (spur) rd_valid_i = 1'b1;
                    end else begin
                        rd_gnt_i = 1'b1;
                        gw = 0;
                    end
                end else rd_gnt_i = 1'b0;
                if (rd_req_o && rd_gnt_i) vcnt = lat;
                if (wdelay == 0) wr_ready_i = 1'b1;
                else if (wr_valid_o) begin
                    if (ww < wdelay) begin
                        wr_ready_i = 1'b0;
                        ww++;
                    end else begin
                        wr_ready_i = 1'b1;
                        ww = 0;
                    end
                end else wr_ready_i = 1'b0;

                if (prev_rd_hold) begin
                    check("rd_req_held", rd_req_o, 1);
                    check("rd_addr_stable", rd_addr_o, prev_rd_addr);
                end
                if (prev_wr_hold) begin
                    check("wr_valid_held", wr_valid_o, 1);
                    check("wr_addr_stable", wr_addr_o, prev_wr_addr);
                end
                if (wr_valid_o) check("no_rd_during_wr", rd_req_o, 0);

                if (acc_clr_o) begin
                    pop_check(0, 0);
                    if (last_clr >= 0 && gap_exp > 0) check("clr_gap", cyc - last_clr, gap_exp);
                    last_clr = cyc;
                end
                if (rd_req_o && rd_gnt_i) begin
                    pop_check(1, int'(rd_addr_o));
                    rd_log.push_back(int'(rd_addr_o));
                    rd_tot++;
                end
                if (mac_en_o) pop_check(2, int'(tap_idx_o));
                if (wr_valid_o && wr_ready_i) begin
                    pop_check(3, int'(wr_addr_o));
                    wr_log.push_back(int'(wr_addr_o));
                    wr_tot++;
                end
                if (busy_o) busy_tot++;
                else last_clr = -1;
                if (rd_req_o) rdreq_tot++;

                prev_rd_hold = rd_req_o && !rd_gnt_i;
                prev_rd_addr = int'(rd_addr_o);
                prev_wr_hold = wr_valid_o && !wr_ready_i;
                prev_wr_addr = int'(wr_addr_o);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_err"}, err_o, 0);
        check({tag, "_rd_req"}, rd_req_o, 0);
        check({tag, "_wr_valid"}, wr_valid_o, 0);
        check({tag, "_acc_clr"}, acc_clr_o, 0);
        check({tag, "_mac_en"}, mac_en_o, 0);
        check({tag, "_tap_idx"}, tap_idx_o, 0);
        check({tag, "_rd_addr"}, rd_addr_o, 0);
        check({tag, "_wr_addr"}, wr_addr_o, 0);
    endtask

    task automatic launch(input int n, input int k, input int src, input int dst, input bit clr);
        expect_run(n, k, src, dst);
        s_rd = rd_tot; s_wr = wr_tot; s_busy = busy_tot; s_rdreq = rdreq_tot;
        s_rdlog = rd_log.size(); s_wrlog = wr_log.size();
        @(negedge clk);
        len_i = LEN_W'(n); ksize_i = K_W'(k);
        src_base_i = ADDR_W'(src); dst_base_i = ADDR_W'(dst);
        start_i = 1'b1; clr_done_i = clr;
        @(negedge clk);
        start_i = 1'b0; clr_done_i = 1'b0;
        check("start_clears_done", done_o, 0);
        check("start_clears_err", err_o, 0);
        check("busy_after_start", busy_o, 1);
        // Scramble the live configuration; the latched copy must be used.
        len_i = 10'd1; ksize_i = 4'd15; src_base_i = 12'hABC; dst_base_i = 12'hDEF;
    endtask

    task automatic finish(input int n, input int k);
        bit ok = 1'b0;
        bit valid = (k != 0) && (k <= n);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got busy_o=1 after 3000 cycles, expected idle");
        end
        @(negedge clk);
        check("model_drained", exp_q.size(), 0);
        check("done_end", done_o, valid ? 1 : 0);
        check("err_end", err_o, valid ? 0 : 1);
        check("reads_per_run", rd_tot - s_rd, valid ? k * (n - k + 1) : 0);
        check("writes_per_run", wr_tot - s_wr, valid ? (n - k + 1) : 0);
        exp_q.delete();
    endtask

    task automatic run_cfg(input int n, input int k, input int src, input int dst,
                           input int gd, input int wd, input bit sp, input int gap);
        gdelay = gd; wdelay = wd; spur = sp; lat = 1; gap_exp = gap;
        launch(n, k, src, dst, 1'b0);
        finish(n, k);
    endtask

    initial begin
        int lit_rd[6];
        int macs;
        lit_rd = '{12'h100, 12'h101, 12'h101, 12'h102, 12'h102, 12'h103};
        rst_i = 1'b1; start_i = 1'b0; clr_done_i = 1'b0;
        len_i = '0; ksize_i = '0; src_base_i = '0; dst_base_i = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        mon_en = 1'b1;

        // Basic run, zero-wait handshakes; each output costs 1+3K+1 = 8 cycles.
        run_cfg(4, 2, 12'h100, 12'h200, 0, 0, 1'b0, 8);
        for (int i = 0; i < 6; i++) check("lit_read_addr", rd_log[s_rdlog + i], lit_rd[i]);
        for (int i = 0; i < 3; i++) check("lit_write_addr", wr_log[s_wrlog + i], 12'h200 + i);

        // K > N: error, one busy cycle, no read requests.
        run_cfg(3, 4, 12'h000, 12'h000, 0, 0, 1'b0, 0);
        check("err_busy_cycles", busy_tot - s_busy, 1);
        check("err_no_rd_req", rdreq_tot - s_rdreq, 0);
        // K = 0 is rejected too.
        run_cfg(4, 0, 12'h000, 12'h000, 0, 0, 1'b0, 0);

        // K = N with stalled grants and stray rd_valid while waiting.
        run_cfg(5, 5, 12'h300, 12'h400, 3, 0, 1'b1, 0);
        check("k_eq_n_write_addr", wr_log[s_wrlog], 12'h400);

        // Write back-pressure, source window wrapping past the top address.
        run_cfg(4, 2, 12'hFFE, 12'h050, 0, 10, 1'b0, 0);
        check("wrap_read0", rd_log[s_rdlog + 2], 12'hFFF);
        check("wrap_read3", rd_log[s_rdlog + 3], 12'h000);
        @(negedge clk);
        clr_done_i = 1'b1;
        @(negedge clk);
        clr_done_i = 1'b0;
        check("clr_done_done", done_o, 0);

        // Asynchronous reset during the second MAC of N=8, K=3.
        gdelay = 0; wdelay = 0; spur = 1'b0; gap_exp = 0;
        launch(8, 3, 12'h010, 12'h300, 1'b0);
        macs = 0;
        for (int c = 0; c < 200 && macs < 2; c++) begin
            @(negedge clk);
            if (mac_en_o) macs++;
        end
        check("saw_second_mac", macs, 2);
        #3;
        mon_en = 1'b0;
        rst_i = 1'b1;
        #1;
        check_all_zero("async_rst");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("post_rst");
        mon_en = 1'b1;
        run_cfg(8, 3, 12'h010, 12'h300, 0, 0, 1'b0, 11);
        check("replay_first_read", rd_log[s_rdlog], 12'h010);
        check("replay_first_write", wr_log[s_wrlog], 12'h300);

        // Start during busy is ignored; then clear+start in the same idle cycle.
        gdelay = 0; wdelay = 0; spur = 1'b0; gap_exp = 0;
        launch(4, 2, 12'h100, 12'h200, 1'b0);
        repeat (5) @(negedge clk);
        len_i = 10'd3; ksize_i = 4'd4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        finish(4, 2);
        launch(5, 5, 12'h020, 12'h040, 1'b1);
        finish(5, 5);

        // An error is cleared by the next accepted start.
        run_cfg(2, 3, 12'h000, 12'h000, 0, 0, 1'b0, 0);
        run_cfg(3, 1, 12'h700, 12'h710, 0, 0, 1'b0, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
